// File: rtl/shot_clock_pkg.sv
// Shared types and helpers for the BCD shot/game clock.
// State encoding, 7-segment patterns ({g,f,e,d,c,b,a}, active-high) and BCD clamping.
package shot_clock_pkg;

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Non-decimal nibbles saturate at 9 so a bad load never shows garbage.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter chain.
// A digit steps down when the chain decrements and every lower digit is 0
// (borrow_i); it wraps 0 -> 9 and passes the borrow upward.
module bcd_down_digit
    import shot_clock_pkg::*;
#(
    parameter logic [3:0] RST_VAL = 4'd0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    input  logic       borrow_i,
    output logic [3:0] q_o,
    output logic       borrow_o
);

    logic [3:0] q_d, q_q;

    // Next digit value: load wins over decrement.
    always_comb begin
        // NOTE: default first, so every path assigns q_d and no latch is inferred.
        q_d = q_q;
        if (load_i) begin
            q_d = bcd_clamp(load_val_i);
        end else if (dec_i && borrow_i) begin
            q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
        end
    end

    // Digit register with synchronous reset to its slice of the preset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking for all sequential state, so every flop samples pre-edge values.
        if (rst_i) q_q <= RST_VAL;
        else       q_q <= q_d;
    end

    assign q_o      = q_q;
    assign borrow_o = borrow_i && (q_q == 4'd0);

endmodule

// File: rtl/shot_clock_bcd.sv
// BCD down-counting shot/game clock with run/pause, reload, low/zero flags,
// 7-segment outputs and a timed expiry horn.
// Optional build macro: SHOT_CLOCK_LZB_EN enables leading-zero blanking on SEG.
// The interval clock runs whenever RUN is high and the value is nonzero outside
// EXPIRED, so the edge that leaves STOP already counts toward the current interval.
module shot_clock_bcd
    import shot_clock_pkg::*;
#(
    parameter int                  DIGITS   = 2,
    parameter logic [4*DIGITS-1:0] PRESET   = 8'h24,
    parameter int                  TICK_DIV = 1000,
    parameter int                  WARN_TH  = 5,
    parameter int                  HORN_CYC = 3000
) (
    input  logic                  CP,
    input  logic                  CR,
    input  logic                  RUN,
    input  logic                  RLD,
    input  logic                  LD,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic [7*DIGITS-1:0]   SEG,
    output logic                  running,
    output logic                  low,
    output logic                  zero,
    output logic                  horn
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HORN_CYC > 1) ? $clog2(HORN_CYC) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HORN_LAST  = HW'(HORN_CYC - 1);
    localparam logic [W-1:0]  ONE        = W'(1);

    state_e         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           horn_q;
    logic [HW-1:0]  horn_cnt_q;

    logic           load;
    logic [W-1:0]   load_val;
    logic           counting;
    logic           tick;
    logic           expire;
    logic [DIGITS:0] borrow;
    logic           unused_borrow_top;

    assign load     = LD || RLD;
    assign load_val = LD ? D : PRESET;

    // The interval advances while RUN is high in COUNT, or on the edge leaving STOP.
    assign counting = RUN && !load &&
                      ((state_q == COUNT) || ((state_q == STOP) && !zero));
    assign tick     = counting && (presc_q == PRESC_LAST);
    assign expire   = tick && (Q == ONE);

    // Digit chain: digit 0 always has a borrow, higher digits borrow from below.
    assign borrow[0] = 1'b1;
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_down_digit #(
            .RST_VAL(PRESET[4*i +: 4])
        ) u_digit (
            .clk_i      (CP),
            .rst_i      (CR),
            .load_i     (load),
            .load_val_i (load_val[4*i +: 4]),
            .dec_i      (tick),
            .borrow_i   (borrow[i]),
            .q_o        (Q[4*i +: 4]),
            .borrow_o   (borrow[i+1])
        );
    end
    // The top digit never borrows while counting, since expiry stops the chain at 0.
    assign unused_borrow_top = borrow[DIGITS];

    // Next state and prescaler: load first, then run/pause/expiry rules.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        if (load) begin
            state_d = (RUN && (load_val != '0)) ? COUNT : STOP;
            presc_d = '0;
        end else begin
            case (state_q)
                STOP: begin
                    if (RUN && !zero) state_d = expire ? EXPIRED : COUNT;
                end
                COUNT: begin
                    if (!RUN)        state_d = STOP;
                    else if (expire) state_d = EXPIRED;
                end
                EXPIRED: state_d = EXPIRED;
                default: state_d = STOP;
            endcase
            if (counting) presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    // State and prescaler registers; CR is sampled synchronously.
    always_ff @(posedge CP) begin
        if (CR) begin
            state_q <= STOP;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    // Horn: rises on the expiry edge, stays high HORN_CYC cycles, cut short by a load.
    always_ff @(posedge CP) begin
        if (CR || load) begin
            horn_q     <= 1'b0;
            horn_cnt_q <= '0;
        end else if (expire) begin
            horn_q     <= 1'b1;
            horn_cnt_q <= HORN_LAST;
        end else if (horn_q) begin
            if (horn_cnt_q == '0) horn_q <= 1'b0;
            else                  horn_cnt_q <= horn_cnt_q - 1'b1;
        end
    end

    // Status flags from the registered value; low compares the decimal value.
    always_comb begin
        int value;
        value = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            value = value * 10 + int'(Q[4*i +: 4]);
        end
        zero    = (Q == '0);
        low     = (value != 0) && (value <= WARN_TH);
        running = (state_q == COUNT);
    end

    assign horn = horn_q;

    // 7-segment decode per digit, digit 0 in the LSBs.
    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
`ifdef SHOT_CLOCK_LZB_EN
        if (i == 0) begin : g_units
            assign SEG[7*i +: 7] = seg_of(Q[4*i +: 4]);
        end else begin : g_upper
            // Blank when this digit and every digit above it are zero.
            assign SEG[7*i +: 7] = (Q[W-1:4*i] == '0) ? SEG_BLANK : seg_of(Q[4*i +: 4]);
        end
`else
        assign SEG[7*i +: 7] = seg_of(Q[4*i +: 4]);
`endif
    end

endmodule

// File: tb/tb_shot_clock_bcd.sv
// Self-checking bench for shot_clock_bcd (DIGITS=2, PRESET=24, TICK_DIV=4,
// WARN_TH=5, HORN_CYC=3). The reference model keeps the clock as a plain
// decimal integer with an interval phase and a horn-remaining count.
module tb_shot_clock_bcd;

    localparam int TD         = 4;
    localparam int HC         = 3;
    localparam int WT         = 5;
    localparam int PRESET_DEC = 24;

    localparam int M_STOP  = 0;
    localparam int M_COUNT = 1;
    localparam int M_EXP   = 2;

    logic        CP  = 1'b0;
    logic        CR  = 1'b0;
    logic        RUN = 1'b0;
    logic        RLD = 1'b0;
    logic        LD  = 1'b0;
    logic [7:0]  D   = 8'h00;
    logic [7:0]  Q;
    logic [13:0] SEG;
    logic        running, low, zero, horn;
    logic [25:0] obs;

    int n_vec = 0;
    int n_err = 0;

    int m_val   = 0;
    int m_mode  = M_STOP;
    int m_phase = 0;
    int m_horn  = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    shot_clock_bcd #(
        .DIGITS   (2),
        .PRESET   (8'h24),
        .TICK_DIV (TD),
        .WARN_TH  (WT),
        .HORN_CYC (HC)
    ) dut (
        .CP      (CP),
        .CR      (CR),
        .RUN     (RUN),
        .RLD     (RLD),
        .LD      (LD),
        .D       (D),
        .Q       (Q),
        .SEG     (SEG),
        .running (running),
        .low     (low),
        .zero    (zero),
        .horn    (horn)
    );

    assign obs = {Q, SEG, running, low, zero, horn};

    initial forever #5 CP = ~CP;

    function automatic int clamp_dec(input logic [7:0] v);
        int t, u;
        t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        u = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return t * 10 + u;
    endfunction

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_update();
        bit live;
        if (CR) begin
            m_val = PRESET_DEC; m_mode = M_STOP; m_phase = 0; m_horn = 0;
        end else if (LD || RLD) begin
            m_val   = LD ? clamp_dec(D) : PRESET_DEC;
            m_phase = 0;
            m_horn  = 0;
            m_mode  = (RUN && m_val != 0) ? M_COUNT : M_STOP;
        end else begin
            if (m_horn > 0) m_horn--;
            live = RUN && (m_mode == M_COUNT || (m_mode == M_STOP && m_val != 0));
            if (m_mode == M_COUNT && !RUN) m_mode = M_STOP;
            if (live) begin
                m_mode = M_COUNT;
                if (m_phase == TD - 1) begin
                    m_phase = 0;
                    m_val--;
                    if (m_val == 0) begin
                        m_mode = M_EXP;
                        m_horn = HC;
                    end
                end else begin
                    m_phase++;
                end
            end
        end
    endtask

    function automatic logic [25:0] exp_vec();
        int tens, ones;
        logic [6:0] s1;
        tens = m_val / 10;
        ones = m_val % 10;
        s1   = seg_tab[tens];
`ifdef SHOT_CLOCK_LZB_EN
        if (tens == 0) s1 = 7'h00;
`endif
        return {4'(tens), 4'(ones), s1, seg_tab[ones],
                m_mode == M_COUNT, (m_val > 0) && (m_val <= WT), m_val == 0, m_horn > 0};
    endfunction

    task automatic step();
        model_update();
        @(posedge CP);
        #1;
    endtask

    task automatic test_reset();
        CR = 1'b1; RUN = 1'b0; LD = 1'b0; RLD = 1'b0;
        step();
        CR = 1'b0;
        n_vec++; if (Q !== 8'h24) begin n_err++; $display("FAIL reset_q got=%h exp=24", Q); end
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running got=%b exp=0", running); end
        n_vec++; if (horn !== 1'b0) begin n_err++; $display("FAIL reset_horn got=%b exp=0", horn); end
        n_vec++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got=%b exp=0", zero); end
        n_vec++; if (SEG !== {7'h5B, 7'h66}) begin n_err++; $display("FAIL reset_seg got=%h exp=%h", SEG, {7'h5B, 7'h66}); end
    endtask

    task automatic test_countdown();
        bit low_seen = 1'b0;
        int horn_cnt = 0;
        RUN = 1'b1;
        for (int k = 1; k <= 96; k++) begin
            step();
            n_vec++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL countdown k=%0d got=%h exp=%h", k, obs, exp_vec()); end
            if (k == 4) begin
                n_vec++; if (Q !== 8'h23) begin n_err++; $display("FAIL first_tick got=%h exp=23", Q); end
            end
            if (k == 20) begin
                n_vec++; if (Q !== 8'h19) begin n_err++; $display("FAIL borrow_20_19 got=%h exp=19", Q); end
            end
            if (low && !low_seen) begin
                low_seen = 1'b1;
                n_vec++; if (Q !== 8'h05) begin n_err++; $display("FAIL low_first got=%h exp=05", Q); end
            end
        end
        n_vec++; if ({zero, horn} !== 2'b11) begin n_err++; $display("FAIL expiry got zero,horn=%b exp=11", {zero, horn}); end
        horn_cnt = int'(horn);
        for (int k = 0; k < 10; k++) begin
            step();
            n_vec++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL expired_hold k=%0d got=%h exp=%h", k, obs, exp_vec()); end
            n_vec++;
            if ({Q, running} !== 9'h000) begin n_err++; $display("FAIL expired_q got Q=%h running=%b exp 00/0", Q, running); end
            horn_cnt += int'(horn);
        end
        n_vec++; if (horn_cnt != HC) begin n_err++; $display("FAIL horn_len got=%0d exp=%0d", horn_cnt, HC); end
    endtask

    task automatic test_pause();
        int edges = 0;
        D = 8'h10; LD = 1'b1; RUN = 1'b1;
        step();
        LD = 1'b0;
        step(); step();
        n_vec++; if (obs !== exp_vec()) begin n_err++; $display("FAIL pause_pre got=%h exp=%h", obs, exp_vec()); end
        RUN = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            n_vec++;
            if ({Q, running} !== {8'h10, 1'b0}) begin n_err++; $display("FAIL paused k=%0d got Q=%h running=%b exp 10/0", k, Q, running); end
        end
        RUN = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_vec++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL resume k=%0d got=%h exp=%h", k, obs, exp_vec()); end
            if (Q == 8'h09) begin edges = k; break; end
        end
        n_vec++; if (edges != 2) begin n_err++; $display("FAIL resume_latency got=%0d exp=2", edges); end
    endtask

    task automatic test_load();
        D = 8'hAB; LD = 1'b1; RUN = 1'b1;
        step();
        LD = 1'b0;
        n_vec++; if ({Q, running} !== {8'h99, 1'b1}) begin n_err++; $display("FAIL load_clamp got Q=%h running=%b exp 99/1", Q, running); end
        D = 8'h37; LD = 1'b1; RLD = 1'b1;
        step();
        LD = 1'b0; RLD = 1'b0;
        n_vec++; if (Q !== 8'h37) begin n_err++; $display("FAIL ld_over_rld got=%h exp=37", Q); end
        RLD = 1'b1;
        step();
        RLD = 1'b0;
        n_vec++; if (Q !== 8'h24) begin n_err++; $display("FAIL reload got=%h exp=24", Q); end
        D = 8'h00; LD = 1'b1;
        step();
        LD = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if ({running, zero, horn} !== 3'b010) begin n_err++; $display("FAIL load_zero k=%0d got run,zero,horn=%b exp=010", k, {running, zero, horn}); end
            step();
        end
        D = 8'h01; LD = 1'b1;
        step();
        LD = 1'b0;
        repeat (4) step();
        n_vec++; if ({Q, horn} !== {8'h00, 1'b1}) begin n_err++; $display("FAIL short_expiry got Q=%h horn=%b exp 00/1", Q, horn); end
        D = 8'h12; LD = 1'b1;
        step();
        LD = 1'b0;
        n_vec++; if ({Q, horn} !== {8'h12, 1'b0}) begin n_err++; $display("FAIL horn_cut got Q=%h horn=%b exp 12/0", Q, horn); end
        n_vec++; if (obs !== exp_vec()) begin n_err++; $display("FAIL load_model got=%h exp=%h", obs, exp_vec()); end
    endtask

    task automatic test_lzb();
        logic [6:0] exp_d1;
`ifdef SHOT_CLOCK_LZB_EN
        exp_d1 = 7'h00;
`else
        exp_d1 = 7'h3F;
`endif
        D = 8'h07; LD = 1'b1; RUN = 1'b0;
        step();
        LD = 1'b0;
        n_vec++; if (SEG[13:7] !== exp_d1) begin n_err++; $display("FAIL lzb_digit1 got=%h exp=%h", SEG[13:7], exp_d1); end
        n_vec++; if (SEG[6:0] !== 7'h07) begin n_err++; $display("FAIL lzb_digit0 got=%h exp=07", SEG[6:0]); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            CR  = ($urandom_range(0, 199) == 0);
            LD  = ($urandom_range(0, 29) == 0);
            RLD = ($urandom_range(0, 39) == 0);
            RUN = ($urandom_range(0, 7) != 0);
            D   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom_range(0, 9))};
            step();
            n_vec++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL random k=%0d got=%h exp=%h", k, obs, exp_vec()); end
        end
        CR = 1'b0; LD = 1'b0; RLD = 1'b0; RUN = 1'b0;
    endtask

    initial begin
        #6;
        test_reset();
        test_countdown();
        test_pause();
        test_load();
        test_lzb();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
